// File: rtl/uart_axi_fifo_if.sv
// axi_lite_if: AXI4-Lite bus bundle (32-bit address and data).
//   slave modport  : awaddr/awvalid, wdata/wstrb/wvalid, bready, araddr/arvalid,
//                    rready in; awready, wready, bvalid/bresp, arready,
//                    rvalid/rdata/rresp out
//   master modport : mirror image of slave
interface axi_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/uart_axi_fifo.sv
// uart_axi_fifo: AXI4-Lite console UART with TX FIFO, programmable baud
// divisor and 8N1 serial output.
//   Registers: BASE+0 TXDATA (W: push byte, R: 0)
//              BASE+4 STATUS (R: [0] full, [1] empty, [2] busy, [15:8] count)
//              BASE+8 DIV    (R/W: bit time = DIV+1 clocks)
// Ports:
//   clk     in   clock, all logic on posedge
//   reset_n in   asynchronous active-low reset
//   s       AXI4-Lite slave
//   tx      out  serial line, idle high
//   tx_irq  out  high while FIFO count <= FIFO_DEPTH/2
module uart_axi_fifo #(
  parameter logic [31:0] BASE_ADDR  = 32'ha00003f8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd867,
  parameter bit          SIM_ECHO   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  axi_lite_if.slave  s,
  output logic       tx,
  output logic       tx_irq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] ADDR_TX  = BASE_ADDR;
  localparam logic [31:0] ADDR_ST  = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_DIV = BASE_ADDR + 32'd8;

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // Reset asserts asynchronously, releases two clocks after reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // ---------------- write channel ----------------
  logic        aw_held_q, w_held_q, awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] awaddr_q, wr_addr;
  logic [15:0] wdata_q, wr_data;
  logic        aw_hs, w_hs, commit;
  logic        is_tx, is_st, is_div;
  logic        full, empty, push, pop;
  logic [15:0] div_reg_q;

  assign aw_hs   = s.awvalid & awready_q;
  assign w_hs    = s.wvalid & wready_q;
  // Commit as soon as both halves are available, held or handshaking now.
  assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_addr = aw_held_q ? awaddr_q : s.awaddr;
  assign wr_data = w_held_q ? wdata_q : s.wdata[15:0];
  assign is_tx   = (wr_addr == ADDR_TX);
  assign is_st   = (wr_addr == ADDR_ST);
  assign is_div  = (wr_addr == ADDR_DIV);
  assign push    = commit & is_tx & ~full;

  always_comb begin
    bresp_d = 2'b00;
    if (!(is_tx | is_st | is_div)) bresp_d = 2'b10;
    else if (is_tx & full)         bresp_d = 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      div_reg_q <= DIV_RESET;
    end else begin
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        awready_q <= 1'b0;
        wready_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= bresp_d;
        if (is_div) div_reg_q <= wr_data;
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          awaddr_q  <= s.awaddr;
          awready_q <= 1'b0;
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          wdata_q  <= s.wdata[15:0];
          wready_q <= 1'b0;
        end
        if (bvalid_q && s.bready) begin
          bvalid_q  <= 1'b0;
          bresp_q   <= '0;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
        end
      end
    end
  end

  assign s.awready = awready_q;
  assign s.wready  = wready_q;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;

  logic unused_bits;
  assign unused_bits = ^{s.wdata[31:16], s.wstrb};

  // ---------------- FIFO ----------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    fifo_head;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign fifo_head = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign tx_irq = (count_q <= CW'(FIFO_DEPTH / 2));

  // ---------------- TX FSM ----------------
  tx_state_e   tx_state_q;
  logic [15:0] div_q, baud_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shreg_q;
  logic        tx_q;
  logic        baud_done;

  assign baud_done = (baud_cnt_q == div_q);
  // Next byte is taken from IDLE, or straight out of the last STOP clock.
  assign pop = ~empty & ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & baud_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      div_q      <= '0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (pop) begin
            shreg_q    <= fifo_head;
            div_q      <= div_reg_q;
            baud_cnt_q <= '0;
            tx_q       <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= shreg_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shreg_q   <= {1'b0, shreg_q[7:1]};
              tx_q      <= shreg_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        TX_STOP: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            if (pop) begin
              shreg_q    <= fifo_head;
              div_q      <= div_reg_q;
              tx_q       <= 1'b0;
              tx_state_q <= TX_START;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx = tx_q;

  if (SIM_ECHO) begin : g_echo
    always_ff @(posedge clk) begin
      if (rst_n && pop) $write("%c", fifo_head);
    end
  end

  // ---------------- read channel ----------------
  rd_state_e   rd_state_q;
  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        busy;

  assign busy = (tx_state_q != TX_IDLE);

  always_comb begin
    rdata_d = '0;
    rresp_d = 2'b00;
    if (s.araddr == ADDR_ST)       rdata_d = {16'b0, 8'(count_q), 5'b0, busy, empty, full};
    else if (s.araddr == ADDR_DIV) rdata_d = {16'b0, div_reg_q};
    else if (s.araddr != ADDR_TX)  rresp_d = 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (s.arvalid && arready_q) begin
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (s.rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign s.arready = arready_q;
  assign s.rvalid  = rvalid_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;

endmodule

// File: tb/tb_uart_axi_fifo.sv
// tb_uart_axi_fifo: scoreboard bench for uart_axi_fifo. Stimulus pushes
// expected B/R responses and serial frames into queues; independent monitors
// pop and compare when the DUT presents them.
module tb_uart_axi_fifo;
  localparam logic [31:0] BASE  = 32'ha00003f8;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic tx, tx_irq;

  axi_lite_if bus();

  uart_axi_fifo #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .DIV_RESET (16'd867),
    .SIM_ECHO  (1'b0)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .s      (bus),
    .tx     (tx),
    .tx_irq (tx_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  typedef struct {
    logic [7:0]  data;
    int unsigned div;
  } fexp_t;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];
  fexp_t      exp_tx[$];
  logic       frame_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  task automatic push_frame(input logic [7:0] b, input int unsigned d);
    fexp_t e;
    e.data = b;
    e.div  = d;
    exp_tx.push_back(e);
  endtask

  // ---------------- B monitor ----------------
  initial begin : b_mon
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.bvalid && bus.bready) begin
        if (exp_b.size() == 0) begin
          timeout_fail("b_unexpected_response");
        end else begin
          e = exp_b.pop_front();
          chk("bresp", 32'(bus.bresp), 32'(e));
        end
      end
    end
  end

  // ---------------- R monitor ----------------
  initial begin : r_mon
    rexp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.rvalid && bus.rready) begin
        if (exp_r.size() == 0) begin
          timeout_fail("r_unexpected_response");
        end else begin
          e = exp_r.pop_front();
          chk("rdata", bus.rdata, e.data);
          chk("rresp", 32'(bus.rresp), 32'(e.resp));
        end
      end
    end
  end

  // ---------------- serial frame monitor ----------------
  // Checks every clock of a frame: start, 8 data bits LSB first, stop.
  initial begin : tx_mon
    fexp_t       e;
    int unsigned bt, bad_k;
    logic        exp_lvl, aborted, bad;
    int          n;
    forever begin
      @(negedge clk);
      if (reset_n && tx === 1'b0) begin
        if (exp_tx.size() == 0) begin
          timeout_fail("tx_unexpected_frame");
          n = 0;
          while (tx !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
          end
        end else begin
          e = exp_tx.pop_front();
          frame_active = 1'b1;
          aborted = 1'b0;
          bad = 1'b0;
          bad_k = 0;
          for (int unsigned k = 0; k < 10 * (e.div + 1); k++) begin
            if (k != 0) @(negedge clk);
            if (!reset_n) begin
              aborted = 1'b1;
              break;
            end
            bt = k / (e.div + 1);
            if (bt == 0)      exp_lvl = 1'b0;
            else if (bt == 9) exp_lvl = 1'b1;
            else              exp_lvl = e.data[bt-1];
            if (tx !== exp_lvl && !bad) begin
              bad = 1'b1;
              bad_k = k;
            end
          end
          frame_active = 1'b0;
          if (!aborted) begin
            checks++;
            if (bad) begin
              errors++;
              $display("FAIL tx_frame byte=0x%02h div=%0d first wrong level at clock %0d of frame",
                       e.data, e.div, bad_k);
            end
          end
        end
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] er);
    int   n;
    logic aok, wok;
    exp_b.push_back(er);
    @(posedge clk);
    #1;
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    bus.wdata   = d;
    bus.wvalid  = 1'b1;
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 50) begin
      @(negedge clk);
      aok = bus.awvalid & bus.awready;
      wok = bus.wvalid & bus.wready;
      @(posedge clk);
      #1;
      if (aok) bus.awvalid = 1'b0;
      if (wok) bus.wvalid = 1'b0;
      n++;
    end
    if (bus.awvalid || bus.wvalid) begin
      timeout_fail("axi_write_addr_data");
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
    end
    n = 0;
    while (!bus.bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.bvalid) timeout_fail("axi_write_bvalid");
    @(posedge clk);
    #1;
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    int    n;
    logic  ok;
    rexp_t e;
    e.data = ed;
    e.resp = er;
    exp_r.push_back(e);
    @(posedge clk);
    #1;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    n = 0;
    while (bus.arvalid && n < 50) begin
      @(negedge clk);
      ok = bus.arready;
      @(posedge clk);
      #1;
      if (ok) bus.arvalid = 1'b0;
      n++;
    end
    if (bus.arvalid) begin
      timeout_fail("axi_read_addr");
      bus.arvalid = 1'b0;
    end
    n = 0;
    while (!bus.rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rvalid) timeout_fail("axi_read_rvalid");
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || frame_active) && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (exp_tx.size() != 0 || frame_active) timeout_fail("tx_drain");
    repeat (5) @(posedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    timeout_fail("global_watchdog");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    reset_n     = 1'b0;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = 4'hf;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;

    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_tx_irq", 32'(tx_irq), 32'd1);
    chk("reset_awready", 32'(bus.awready), 32'd1);
    chk("reset_wready", 32'(bus.wready), 32'd1);
    chk("reset_arready", 32'(bus.arready), 32'd1);
    chk("reset_bvalid", 32'(bus.bvalid), 32'd0);
    chk("reset_rvalid", 32'(bus.rvalid), 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_bresp", 32'(bus.bresp), 32'd0);
    chk("reset_rresp", 32'(bus.rresp), 32'd0);

    axi_read(BASE + 32'd8, 32'd867, 2'd0);
    axi_read(BASE + 32'd4, 32'h0000_0002, 2'd0);

    // 0x55 at DIV=3: alternating bits, 4 clocks each
    axi_write(BASE + 32'd8, 32'd3, 2'd0);
    push_frame(8'h55, 3);
    axi_write(BASE, 32'h55, 2'd0);
    drain(2000);

    // W three cycles ahead of AW to DIV, B held by bready low
    exp_b.push_back(2'd0);
    bus.bready = 1'b0;
    @(posedge clk);
    #1;
    bus.wdata  = 32'h0000_0007;
    bus.wvalid = 1'b1;
    @(negedge clk);
    chk("split_wready", 32'(bus.wready), 32'd1);
    @(posedge clk);
    #1 bus.wvalid = 1'b0;
    @(negedge clk);
    chk("split_wready_drop", 32'(bus.wready), 32'd0);
    chk("split_awready_kept", 32'(bus.awready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.awaddr  = BASE + 32'd8;
    bus.awvalid = 1'b1;
    @(negedge clk);
    chk("split_b_not_early", 32'(bus.bvalid), 32'd0);
    @(posedge clk);
    #1 bus.awvalid = 1'b0;
    @(negedge clk);
    chk("split_b_latency", 32'(bus.bvalid), 32'd1);
    chk("split_awready_low", 32'(bus.awready), 32'd0);
    repeat (2) @(negedge clk);
    chk("split_b_hold", 32'(bus.bvalid), 32'd1);
    @(posedge clk);
    #1 bus.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("split_ready_back", {29'd0, bus.awready, bus.wready, bus.bvalid}, 32'b110);
    axi_read(BASE + 32'd8, 32'd7, 2'd0);

    // Unmapped address and STATUS/TXDATA access types
    axi_read(BASE + 32'd12, 32'd0, 2'd2);
    axi_write(BASE + 32'd12, 32'h0000_1234, 2'd2);
    axi_read(BASE + 32'd8, 32'd7, 2'd0);
    axi_read(BASE + 32'd4, 32'h0000_0002, 2'd0);
    axi_write(BASE + 32'd4, 32'h0000_ffff, 2'd0);
    axi_read(BASE, 32'd0, 2'd0);
    axi_read(BASE + 32'd8, 32'd7, 2'd0);

    // DIV change mid-frame applies to the following frame only
    axi_write(BASE + 32'd8, 32'd3, 2'd0);
    push_frame(8'h41, 3);
    axi_write(BASE, 32'h41, 2'd0);
    push_frame(8'h42, 1);
    axi_write(BASE, 32'h42, 2'd0);
    repeat (6) @(posedge clk);
    axi_write(BASE + 32'd8, 32'd1, 2'd0);
    drain(2000);

    // Overfill while the line is busy on a long frame
    axi_write(BASE + 32'd8, 32'd49, 2'd0);
    push_frame(8'h30, 49);
    axi_write(BASE, 32'h30, 2'd0);
    repeat (4) @(posedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      push_frame(8'(8'h61 + i), 49);
      axi_write(BASE, 32'(8'h61 + i), 2'd0);
    end
    axi_write(BASE, 32'h7a, 2'd2);
    axi_read(BASE + 32'd4, 32'h0000_1005, 2'd0);
    @(negedge clk);
    chk("tx_irq_full", 32'(tx_irq), 32'd0);
    drain(20000);
    axi_read(BASE + 32'd4, 32'h0000_0002, 2'd0);
    @(negedge clk);
    chk("tx_irq_empty", 32'(tx_irq), 32'd1);

    // Reset during the data bits
    axi_write(BASE + 32'd8, 32'd3, 2'd0);
    push_frame(8'h5a, 3);
    axi_write(BASE, 32'h5a, 2'd0);
    push_frame(8'h5b, 3);
    axi_write(BASE, 32'h5b, 2'd0);
    repeat (10) @(posedge clk);
    chk("frame_in_progress", 32'(frame_active), 32'd1);
    #1 reset_n = 1'b0;
    #1 chk("reset_tx_immediate", 32'(tx), 32'd1);
    repeat (3) @(posedge clk);
    exp_tx.delete();
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    axi_read(BASE + 32'd4, 32'h0000_0002, 2'd0);
    axi_read(BASE + 32'd8, 32'd867, 2'd0);
    repeat (100) @(posedge clk);

    chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
    chk("r_queue_drained", 32'(exp_r.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
